// File: rtl/lfu_button_encoder.sv
// lfu_button_encoder: sync, debounce and edge-detect four buttons,
// then deliver one held request at a time. Option: LFU_BTN_ACTIVE_LOW_EN.
module lfu_button_encoder #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned HOLD_CYCLES     = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] btn_raw,
   output logic       b1,
   output logic       b2,
   output logic       b3,
   output logic       b4,
   output logic       busy,
   output logic [7:0] drop_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
   localparam logic [25:0] HD_LAST = 26'(HOLD_CYCLES - 1);

   logic [3:0]  btn_in;
   logic [3:0]  sync1;
   logic [3:0]  sync2;
   logic [3:0]  deb;
   logic [3:0]  deb_q;
   logic [15:0] db_cnt [4];
   logic [3:0]  press;

   state_t      state_q;
   state_t      state_d;
   logic [25:0] hold_cnt;
   logic [25:0] hold_d;

   logic [3:0]  req_q;
   logic [3:0]  req_d;
   logic [3:0]  sel;
   logic [3:0]  lost;
   logic [8:0]  drop_sum;
   logic [7:0]  drop_d;
   logic        busy_d;

`ifdef LFU_BTN_ACTIVE_LOW_EN
   assign btn_in = ~btn_raw;
`else
   assign btn_in = btn_raw;
`endif

   function automatic logic [2:0] pop4(input logic [3:0] v);
      return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
   endfunction

   // two-flop synchroniser for the raw buttons
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   // per-button debouncer: flip only after a sustained difference
   always_ff @(posedge clk) begin
      if (rst) begin
         deb <= '0;
         for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 16'd1;
            end
         end
      end
   end

   // registered copy of the debounced level for rise detection
   always_ff @(posedge clk) begin
      if (rst) deb_q <= '0;
      else     deb_q <= deb;
   end

   assign press = deb & ~deb_q;

   // FSM state and hold/gap counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         hold_cnt <= '0;
      end else begin
         state_q  <= state_d;
         hold_cnt <= hold_d;
      end
   end

   // next state: accept in IDLE, then count out HOLD and GAP
   always_comb begin
      state_d = state_q;
      hold_d  = hold_cnt;
      unique case (state_q)
         IDLE: begin
            if (|press) begin
               state_d = HOLD;
               hold_d  = HD_LAST;
            end
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               state_d = GAP;
               hold_d  = HD_LAST;
            end else begin
               hold_d = hold_cnt - 26'd1;
            end
         end
         GAP: begin
            if (hold_cnt == '0) state_d = IDLE;
            else                hold_d  = hold_cnt - 26'd1;
         end
         default: begin
            state_d = IDLE;
            hold_d  = '0;
         end
      endcase
   end

   // outputs: lowest pressed button wins, every other event is a drop
   always_comb begin
      sel    = press & (~press + 4'd1);
      req_d  = '0;
      lost   = press;
      busy_d = (state_d != IDLE);
      if (state_q == IDLE) begin
         lost = press & ~sel;
         if (state_d == HOLD) req_d = sel;
      end else if (state_q == HOLD && state_d == HOLD) begin
         req_d = req_q;
      end
      drop_sum = {1'b0, drop_count} + 9'(pop4(lost));
      drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
   end

   // output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         req_q      <= '0;
         busy       <= 1'b0;
         drop_count <= '0;
      end else begin
         req_q      <= req_d;
         busy       <= busy_d;
         drop_count <= drop_d;
      end
   end

   assign b1 = req_q[0];
   assign b2 = req_q[1];
   assign b3 = req_q[2];
   assign b4 = req_q[3];

endmodule

// File: tb/tb_lfu_button_encoder.sv
// tb_lfu_button_encoder: directed scenarios for lfu_button_encoder
// with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=8.
module tb_lfu_button_encoder;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] btn;
   logic [3:0] btn_raw;
   logic       b1;
   logic       b2;
   logic       b3;
   logic       b4;
   logic       busy;
   logic [7:0] drop_count;

`ifdef LFU_BTN_ACTIVE_LOW_EN
   localparam logic [3:0] RAW_IDLE = 4'hF;
`else
   localparam logic [3:0] RAW_IDLE = 4'h0;
`endif

   assign btn_raw = btn ^ RAW_IDLE;

   int pass_cnt = 0;
   int total = 0;

   int hi [4];
   int first [4];
   int busy_hi;
   int busy_first;
   int multi;
   int cyc;

   always #5 clk = ~clk;

   lfu_button_encoder #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .btn_raw(btn_raw),
      .b1(b1),
      .b2(b2),
      .b3(b3),
      .b4(b4),
      .busy(busy),
      .drop_count(drop_count)
   );

   task automatic clr_watch();
      for (int k = 0; k < 4; k++) begin
         hi[k] = 0;
         first[k] = -1;
      end
      busy_hi = 0;
      busy_first = -1;
      multi = 0;
      cyc = 0;
   endtask

   task automatic sample_cycle();
      logic [3:0] v;
      @(posedge clk);
      #1;
      v = {b4, b3, b2, b1};
      for (int k = 0; k < 4; k++) begin
         if (v[k]) begin
            if (hi[k] == 0) first[k] = cyc;
            hi[k]++;
         end
      end
      if (busy) begin
         if (busy_hi == 0) busy_first = cyc;
         busy_hi++;
      end
      if ($countones(v) > 1) multi++;
      cyc++;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      btn = 4'b0000;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      btn = 4'b1111;
      for (int e = 0; e < 3; e++) begin
         @(posedge clk);
         #1;
         total++;
         if ({b4, b3, b2, b1} !== 4'b0000)
            $display("FAIL rst_b got=%b exp=0000", {b4, b3, b2, b1});
         else pass_cnt++;
         total++;
         if (busy !== 1'b0)
            $display("FAIL rst_busy got=%b exp=0", busy);
         else pass_cnt++;
         total++;
         if (drop_count !== 8'd0)
            $display("FAIL rst_drop got=%0d exp=0", drop_count);
         else pass_cnt++;
      end
      rst = 1'b0;
      clr_watch();
      for (int i = 0; i < 40; i++) sample_cycle();
      total++;
      if (first[0] !== 6)
         $display("FAIL rst_b1_rise got=%0d exp=6", first[0]);
      else pass_cnt++;
      total++;
      if (hi[0] !== 8)
         $display("FAIL rst_b1_width got=%0d exp=8", hi[0]);
      else pass_cnt++;
      total++;
      if (hi[1] + hi[2] + hi[3] !== 0)
         $display("FAIL rst_others got=%0d exp=0",
                  hi[1] + hi[2] + hi[3]);
      else pass_cnt++;
      total++;
      if (drop_count !== 8'd3)
         $display("FAIL rst_drop3 got=%0d exp=3", drop_count);
      else pass_cnt++;
      btn = 4'b0000;
      tick(10);
   endtask

   task automatic test_single_press();
      do_reset();
      btn = 4'b0010;
      clr_watch();
      for (int i = 0; i < 40; i++) sample_cycle();
      btn = 4'b0000;
      total++;
      if (first[1] !== 6)
         $display("FAIL sp_b2_rise got=%0d exp=6", first[1]);
      else pass_cnt++;
      total++;
      if (hi[1] !== 8)
         $display("FAIL sp_b2_width got=%0d exp=8", hi[1]);
      else pass_cnt++;
      total++;
      if (busy_hi !== 16)
         $display("FAIL sp_busy_len got=%0d exp=16", busy_hi);
      else pass_cnt++;
      total++;
      if (busy_first !== 6)
         $display("FAIL sp_busy_rise got=%0d exp=6", busy_first);
      else pass_cnt++;
      total++;
      if (hi[0] + hi[2] + hi[3] !== 0)
         $display("FAIL sp_others got=%0d exp=0",
                  hi[0] + hi[2] + hi[3]);
      else pass_cnt++;
      total++;
      if (drop_count !== 8'd0)
         $display("FAIL sp_drop got=%0d exp=0", drop_count);
      else pass_cnt++;
      tick(10);
   endtask

   task automatic test_bounce();
      do_reset();
      clr_watch();
      btn = 4'b0100;
      for (int i = 0; i < 30; i++) begin
         sample_cycle();
         if (i == 2) btn = 4'b0000;
      end
      total++;
      if (hi[2] !== 0 || busy_hi !== 0)
         $display("FAIL bounce_short got=%0d/%0d exp=0/0",
                  hi[2], busy_hi);
      else pass_cnt++;
      total++;
      if (drop_count !== 8'd0)
         $display("FAIL bounce_drop got=%0d exp=0", drop_count);
      else pass_cnt++;
      clr_watch();
      btn = 4'b0100;
      for (int i = 0; i < 40; i++) begin
         sample_cycle();
         if (i == 4) btn = 4'b0000;
      end
      total++;
      if (first[2] !== 6)
         $display("FAIL bounce_b3_rise got=%0d exp=6", first[2]);
      else pass_cnt++;
      total++;
      if (hi[2] !== 8)
         $display("FAIL bounce_b3_width got=%0d exp=8", hi[2]);
      else pass_cnt++;
      tick(10);
   endtask

   task automatic test_priority_drop();
      do_reset();
      clr_watch();
      btn = 4'b0001;
      for (int i = 0; i < 40; i++) begin
         sample_cycle();
         if (i == 1) btn[3] = 1'b1;
         if (i == 5) btn[3] = 1'b0;
         if (i == 9) btn[3] = 1'b1;
      end
      btn = 4'b0000;
      total++;
      if (drop_count !== 8'd2)
         $display("FAIL pd_drop got=%0d exp=2", drop_count);
      else pass_cnt++;
      total++;
      if (hi[3] !== 0)
         $display("FAIL pd_b4 got=%0d exp=0", hi[3]);
      else pass_cnt++;
      total++;
      if (hi[0] !== 8)
         $display("FAIL pd_b1_width got=%0d exp=8", hi[0]);
      else pass_cnt++;
      total++;
      if (busy_hi !== 16 || busy !== 1'b0)
         $display("FAIL pd_idle got=%0d/%b exp=16/0",
                  busy_hi, busy);
      else pass_cnt++;
      tick(10);
   endtask

   task automatic test_saturation();
      do_reset();
      clr_watch();
      for (int i = 0; i < 1000; i++) begin
         btn = ((i / 5) % 2 == 0) ? 4'b1111 : 4'b0000;
         sample_cycle();
      end
      btn = 4'b0000;
      tick(40);
      total++;
      if (drop_count !== 8'd255)
         $display("FAIL sat_drop got=%0d exp=255", drop_count);
      else pass_cnt++;
      total++;
      if (multi !== 0)
         $display("FAIL sat_onehot got=%0d exp=0", multi);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      int t;
      btn = 4'b0001;
      t = 0;
      while (b1 !== 1'b1 && t < 20) begin
         @(posedge clk);
         #1;
         t++;
      end
      tick(2);
      total++;
      if (b1 !== 1'b1 || busy !== 1'b1)
         $display("FAIL mr_hold got=%b/%b exp=1/1", b1, busy);
      else pass_cnt++;
      rst = 1'b1;
      btn = 4'b0000;
      @(posedge clk);
      #1;
      total++;
      if (b1 !== 1'b0 || busy !== 1'b0)
         $display("FAIL mr_out got=%b/%b exp=0/0", b1, busy);
      else pass_cnt++;
      total++;
      if (drop_count !== 8'd0)
         $display("FAIL mr_drop got=%0d exp=0", drop_count);
      else pass_cnt++;
      rst = 1'b0;
      tick(10);
      clr_watch();
      btn = 4'b0001;
      for (int i = 0; i < 40; i++) sample_cycle();
      btn = 4'b0000;
      total++;
      if (first[0] !== 6 || hi[0] !== 8)
         $display("FAIL mr_fresh got=%0d/%0d exp=6/8",
                  first[0], hi[0]);
      else pass_cnt++;
      total++;
      if (busy_hi !== 16)
         $display("FAIL mr_busy got=%0d exp=16", busy_hi);
      else pass_cnt++;
      tick(10);
   endtask

   task automatic test_idle_after_reset();
      do_reset();
      clr_watch();
      for (int i = 0; i < 20; i++) sample_cycle();
      total++;
      if (hi[0] + hi[1] + hi[2] + hi[3] + busy_hi !== 0)
         $display("FAIL idle_spurious got=%0d exp=0",
                  hi[0] + hi[1] + hi[2] + hi[3] + busy_hi);
      else pass_cnt++;
      total++;
      if (drop_count !== 8'd0)
         $display("FAIL idle_drop got=%0d exp=0", drop_count);
      else pass_cnt++;
      clr_watch();
      btn = 4'b0001;
      for (int i = 0; i < 40; i++) sample_cycle();
      btn = 4'b0000;
      total++;
      if (first[0] !== 6 || hi[0] !== 8)
         $display("FAIL idle_b1 got=%0d/%0d exp=6/8",
                  first[0], hi[0]);
      else pass_cnt++;
      tick(10);
   endtask

   initial begin
      rst = 1'b1;
      btn = 4'b0000;
      test_reset();
      test_single_press();
      test_bounce();
      test_priority_drop();
      test_saturation();
      test_mid_reset();
      test_idle_after_reset();
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule

// File: doc/lfu_button_encoder.md
# lfu_button_encoder

Front-end request source for the `lfu` tracker. Conditions four raw push-button inputs and turns each qualified press into a one-hot request on `b1`–`b4`. It synchronises the inputs, debounces each button, and detects the rising edge. Each request is held long enough for the slow, timer-clocked `lfu` state machine to sample it, followed by an idle gap. Presses that cannot be delivered are counted, not queued.

## Interface
- `DEBOUNCE_CYCLES`, 16: consecutive `clk` cycles a synchronised level must hold before it is accepted; legal range 1–65535.
- `HOLD_CYCLES`, 25_000_000: `clk` cycles a request stays asserted; the following gap has the same length. Legal range 1–2^26-1.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  asynchronous raw buttons; bit 0 maps to `b1`, bit 3 maps to `b4`.
- `b1`, `b2`, `b3`, `b4`  out  1 each  one-hot request to `lfu`; all registered.
- `busy`  out  1  high whenever the FSM is not in IDLE; registered.
- `drop_count`  out  8  number of presses lost, saturating at 255; registered.

## Operation
- **Per-button pipeline:**
  - 2-flop synchroniser.
  - Debouncer: a counter runs while the synchronised level differs from the debounced level. It clears whenever the two levels are equal. When the count reaches `DEBOUNCE_CYCLES`, the debounced level flips and the counter clears.
- **Press event:** the debounced level goes 0→1, detected against a registered copy of the debounced level. It lasts one cycle per press. A held button produces exactly one event.
- **FSM states:** IDLE, HOLD, GAP.
  - **IDLE:** if any press event occurs, select the lowest-index pressed button (priority `b1` > `b2` > `b3` > `b4`). Load the hold counter and go to HOLD; the selected output rises at that edge.
  - **HOLD:** exactly one output is high. After `HOLD_CYCLES` cycles, clear all outputs and go to GAP.
  - **GAP:** all outputs are low for `HOLD_CYCLES` cycles, then go to IDLE.
- **Drops:**
  - Non-selected simultaneous events in IDLE each count as one drop.
  - Every event during HOLD or GAP counts as one drop.
  - N drops in one cycle add N, saturating at 255; drops never wrap.
- **Outputs:** `b1`–`b4` are never multi-hot. `busy` = (state ≠ IDLE).
- **Reset** (any state, including mid-HOLD): at the reset edge:
  - state goes to IDLE;
  - all `b*` = 0, `busy` = 0, `drop_count` = 0;
  - synchroniser flops, debounced levels and edge registers are cleared (0 = not pressed);
  - counters are cleared.

## Timing
- Raw input rises and is stable before edge E0. The synchroniser output is valid after E1, and the debounced level flips at E1+`DEBOUNCE_CYCLES`. The press event occurs in that cycle, and the request is asserted at edge E0+`DEBOUNCE_CYCLES`+2.
- Request width is exactly `HOLD_CYCLES` cycles. `busy` is high for exactly 2×`HOLD_CYCLES` cycles, starting on the same edge the request rises.
- Minimum spacing between two delivered requests is 2×`HOLD_CYCLES` cycles.
- A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes the debounced level.
- A press event arriving in the same cycle that GAP ends (transition to IDLE) is dropped. Only events seen while the state is IDLE are accepted.

## Configuration
- `LFU_BTN_ACTIVE_LOW_EN`:
  - Defined: `btn_raw` is inverted before the synchroniser, for boards with active-low keys. Reset still clears internal levels to "not pressed". The first post-reset cycles cannot create an event, because the synchroniser output is also reset to "not pressed" and a press needs a debounced 0→1 transition.
  - Undefined: `btn_raw` is active-high and used directly.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=8, without `LFU_BTN_ACTIVE_LOW_EN` unless stated.
- **Reset:** assert `rst` for 3 cycles with `btn_raw`=4'b1111 → all `b*`=0, `busy`=0, `drop_count`=0 during reset. After release, exactly one `b1` request follows, and `drop_count`=3 from the simultaneous events.
- **Single press:** `btn_raw`=4'b0010 at E0, held 40 cycles → `b2` rises at E0+6 for exactly 8 cycles; `busy` is high for 16 cycles; no second request.
- **Bounce rejection:** `btn_raw[2]` pulses high for 3 cycles, then low → no request, `drop_count`=0. The same input held for 5 cycles → one `b3` request.
- **Priority and drop counting:** during HOLD, press `btn_raw[3]`, then release and re-press it for a second event → `drop_count`=2, `b4` is never asserted, and the FSM returns to IDLE after GAP.
- **Saturation and mid-operation reset:** generate 300 drops → `drop_count` holds 255. Then assert `rst` during HOLD with `b1` high → at that edge `b1`=0, `busy`=0, `drop_count`=0. A fresh press afterwards yields a normal request.
- **Active-low build:** with `LFU_BTN_ACTIVE_LOW_EN` defined, idle `btn_raw`=4'b1111 and `btn_raw[0]` driven to 0 → `b1` request with the same timing as the single-press scenario; no spurious request out of reset.
